// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-fetch stage: widths, instruction field
// positions and opcode class decoding.
package cpu_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 4;
   localparam int STALL_W = 16;

   localparam int OP_LO  = 12;
   localparam int RD_LO  = 8;
   localparam int RS1_LO = 4;
   localparam int RS2_LO = 0;
   localparam int IMM_W  = 4;

   localparam logic [3:0] OP_IMM_BASE  = 4'h8;
   localparam logic [3:0] OP_NOWR_BASE = 4'hC;

   typedef enum logic [1:0] {
      CLS_REG  = 2'd0,
      CLS_IMM  = 2'd1,
      CLS_NOWR = 2'd2
   } op_class_e;

   function automatic op_class_e op_class(input logic [3:0] op);
      if (op >= OP_NOWR_BASE)
         return CLS_NOWR;
      else if (op >= OP_IMM_BASE)
         return CLS_IMM;
      else
         return CLS_REG;
   endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a writer is
// accepted, cleared by writeback or by flushing the writer out of the slot.
module operand_fetch_scoreboard
   import cpu_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          wb_clr_en,
   input  logic [AW-1:0] wb_clr_addr,
   input  logic          fl_clr_en,
   input  logic [AW-1:0] fl_clr_addr,
   input  logic [AW-1:0] look_addr1,
   input  logic [AW-1:0] look_addr2,
   input  logic [AW-1:0] look_addr_rd,
   output logic          hit1,
   output logic          hit2,
   output logic          hit_rd
);

   localparam int N = 1 << AW;

   logic [N-1:0] sb;
   logic [N-1:0] sb_nxt;

   // Next scoreboard: clears first, then set, so a same-cycle set wins.
   always_comb begin
      sb_nxt = sb;
      if (wb_clr_en)
         sb_nxt[wb_clr_addr] = 1'b0;
      if (fl_clr_en)
         sb_nxt[fl_clr_addr] = 1'b0;
      if (set_en)
         sb_nxt[set_addr] = 1'b1;
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sb <= '0;
      else
         sb <= sb_nxt;
   end

   assign hit1   = sb[look_addr1];
   assign hit2   = sb[look_addr2];
   assign hit_rd = sb[look_addr_rd];

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: reads the register file combinationally,
// registers operands into one slot for execute, and stalls on RAW/WAW
// hazards tracked by a pending-write scoreboard.
// Optional macro OPERAND_FETCH_WB_BYPASS_EN: forward same-cycle writeback
// data into the operands and let it lift the matching hazard.
module operand_fetch
   import cpu_pkg::*;
#(
   parameter int DW    = DATA_W,
   parameter int AW    = ADDR_W,
   parameter int CNT_W = STALL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_instr,
   output logic [AW-1:0]    rf_r_addr1,
   output logic [AW-1:0]    rf_r_addr2,
   input  logic [DW-1:0]    rf_r_data1,
   input  logic [DW-1:0]    rf_r_data2,
   input  logic             wb_we,
   input  logic [AW-1:0]    wb_addr,
   input  logic [DW-1:0]    wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_op,
   output logic [AW-1:0]    out_rd,
   output logic             out_we,
   output logic [DW-1:0]    out_a,
   output logic [DW-1:0]    out_b,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [3:0]    op;
   logic [AW-1:0] rd;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   op_class_e     cls;
   logic          writes_rd;
   logic          reads_rs2;
   logic          hit1;
   logic          hit2;
   logic          hit_rd;
   logic          hazard;
   logic          slot_free;
   logic          accept;
   logic          stall_inc;
   logic [DW-1:0] opnd_a;
   logic [DW-1:0] opnd_b_reg;
   logic [DW-1:0] opnd_b;

   assign op  = in_instr[OP_LO +: 4];
   assign rd  = in_instr[RD_LO +: AW];
   assign rs1 = in_instr[RS1_LO +: AW];
   assign rs2 = in_instr[RS2_LO +: AW];

   assign cls       = op_class(op);
   assign writes_rd = (cls != CLS_NOWR);
   assign reads_rs2 = (cls != CLS_IMM);

   assign rf_r_addr1 = rs1;
   assign rf_r_addr2 = rs2;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
   logic byp1;
   logic byp2;
   logic byp_rd;

   assign byp1   = wb_we && (wb_addr == rs1);
   assign byp2   = wb_we && (wb_addr == rs2);
   assign byp_rd = wb_we && (wb_addr == rd);

   assign hazard = (hit1 & ~byp1)
                 | (reads_rs2 & hit2 & ~byp2)
                 | (writes_rd & hit_rd & ~byp_rd);

   assign opnd_a     = byp1 ? wb_data : rf_r_data1;
   assign opnd_b_reg = byp2 ? wb_data : rf_r_data2;
`else
   // Writeback data only matters for the bypass path.
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;

   assign hazard = hit1 | (reads_rs2 & hit2) | (writes_rd & hit_rd);

   assign opnd_a     = rf_r_data1;
   assign opnd_b_reg = rf_r_data2;
`endif

   assign opnd_b = (cls == CLS_IMM) ? {{(DW-IMM_W){1'b0}}, in_instr[IMM_W-1:0]}
                                    : opnd_b_reg;

   assign slot_free = ~out_valid | out_ready;
   assign in_ready  = slot_free & ~hazard & ~flush;
   assign accept    = in_valid & in_ready;
   assign stall_inc = in_valid & slot_free & hazard & ~flush;

   operand_fetch_scoreboard #(.AW(AW)) u_sb (
      .clk          (clk),
      .rst          (rst),
      .set_en       (accept & writes_rd),
      .set_addr     (rd),
      .wb_clr_en    (wb_we),
      .wb_clr_addr  (wb_addr),
      .fl_clr_en    (flush & out_valid & out_we),
      .fl_clr_addr  (out_rd),
      .look_addr1   (rs1),
      .look_addr2   (rs2),
      .look_addr_rd (rd),
      .hit1         (hit1),
      .hit2         (hit2),
      .hit_rd       (hit_rd)
   );

   // Pipeline slot toward execute: flush empties, accept loads, consume drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_rd    <= '0;
         out_we    <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_op    <= op;
         out_rd    <= rd;
         out_we    <= writes_rd;
         out_a     <= opnd_a;
         out_b     <= opnd_b;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of cycles lost to hazards (backpressure not counted).
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_operand_fetch;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int CNT_W = 16;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_instr = 16'h0;
   logic [AW-1:0]    rf_r_addr1;
   logic [AW-1:0]    rf_r_addr2;
   logic [DW-1:0]    rf_r_data1;
   logic [DW-1:0]    rf_r_data2;
   logic             wb_we = 1'b0;
   logic [AW-1:0]    wb_addr = '0;
   logic [DW-1:0]    wb_data = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [3:0]       out_op;
   logic [AW-1:0]    out_rd;
   logic             out_we;
   logic [DW-1:0]    out_a;
   logic [DW-1:0]    out_b;
   logic [CNT_W-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   operand_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rf_r_addr1 (rf_r_addr1),
      .rf_r_addr2 (rf_r_addr2),
      .rf_r_data1 (rf_r_data1),
      .rf_r_data2 (rf_r_data2),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_op     (out_op),
      .out_rd     (out_rd),
      .out_we     (out_we),
      .out_a      (out_a),
      .out_b      (out_b),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   // Register file: Rn resets to n*0x1111, written on the edge by writeback.
   logic [DW-1:0] regs [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs[i] <= DW'(i * 16'h1111);
      end else if (wb_we) begin
         regs[wb_addr] <= wb_data;
      end
   end
   assign rf_r_data1 = regs[in_instr[7:4]];
   assign rf_r_data2 = regs[in_instr[3:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: set of pending registers, one slot, stall counter.
   logic [15:0]   m_pend;
   logic          m_vld;
   logic [3:0]    m_op;
   logic [3:0]    m_rd;
   logic          m_we;
   logic [DW-1:0] m_a;
   logic [DW-1:0] m_b;
   int            m_stall;

   // Compare DUT against the model mid-cycle, then advance the model to the
   // state the coming edge must produce (inputs only change just after edges).
   always @(negedge clk) begin
      logic [3:0]    op, rdf, r1, r2;
      bit            is_imm, wr, rd2, blk1, blk2, blkd, haz, free, exp_ready, acc;
      logic [DW-1:0] na, nb;
      if (rst) begin
         m_pend  <= '0;
         m_vld   <= 1'b0;
         m_op    <= '0;
         m_rd    <= '0;
         m_we    <= 1'b0;
         m_a     <= '0;
         m_b     <= '0;
         m_stall <= 0;
      end else begin
         op     = in_instr[15:12];
         rdf    = in_instr[11:8];
         r1     = in_instr[7:4];
         r2     = in_instr[3:0];
         is_imm = (op >= 4'h8) && (op <= 4'hB);
         wr     = (op <= 4'hB);
         rd2    = !is_imm;
         blk1   = m_pend[r1]  && !(BYP && wb_we && wb_addr == r1);
         blk2   = m_pend[r2]  && !(BYP && wb_we && wb_addr == r2);
         blkd   = m_pend[rdf] && !(BYP && wb_we && wb_addr == rdf);
         haz    = blk1 || (rd2 && blk2) || (wr && blkd);
         free   = !m_vld || out_ready;
         exp_ready = free && !haz && !flush;
         acc    = in_valid && exp_ready;

         chk("rf_r_addr1", 32'(rf_r_addr1), 32'(r1));
         chk("rf_r_addr2", 32'(rf_r_addr2), 32'(r2));
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("out_valid", 32'(out_valid), 32'(m_vld));
         if (m_vld) begin
            chk("out_op", 32'(out_op), 32'(m_op));
            chk("out_rd", 32'(out_rd), 32'(m_rd));
            chk("out_we", 32'(out_we), 32'(m_we));
            chk("out_a", 32'(out_a), 32'(m_a));
            chk("out_b", 32'(out_b), 32'(m_b));
         end
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));

         na = (BYP && wb_we && wb_addr == r1) ? wb_data : regs[r1];
         if (is_imm)
            nb = DW'(r2);
         else
            nb = (BYP && wb_we && wb_addr == r2) ? wb_data : regs[r2];

         if (in_valid && free && haz && !flush && m_stall < 65535)
            m_stall <= m_stall + 1;
         if (wb_we)                  m_pend[wb_addr] <= 1'b0;
         if (flush && m_vld && m_we) m_pend[m_rd]    <= 1'b0;
         if (acc && wr)              m_pend[rdf]     <= 1'b1;

         if (flush) begin
            m_vld <= 1'b0;
         end else if (acc) begin
            m_vld <= 1'b1;
            m_op  <= op;
            m_rd  <= rdf;
            m_we  <= wr;
            m_a   <= na;
            m_b   <= nb;
         end else if (out_ready) begin
            m_vld <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_op"}, 32'(out_op), 32'h0);
      chk({tag, "_out_rd"}, 32'(out_rd), 32'h0);
      chk({tag, "_out_we"}, 32'(out_we), 32'h0);
      chk({tag, "_out_a"}, 32'(out_a), 32'h0);
      chk({tag, "_out_b"}, 32'(out_b), 32'h0);
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'h0);
   endtask

   localparam int S_RAW = BYP ? 3 : 4;

   initial begin
      int q[$];

      // Reset with an instruction already presented.
      rst = 1'b1; in_valid = 1'b1; in_instr = 16'h0123; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk_zero_outputs("reset");
      rst = 1'b0;
      #1;
      chk("first_ready", 32'(in_ready), 32'h1);
      tick();
      in_instr = 16'h1415;
      #1;
      chk("first_valid", 32'(out_valid), 32'h1);
      chk("first_a", 32'(out_a), 32'h2222);
      chk("first_b", 32'(out_b), 32'h3333);
      chk("first_rd", 32'(out_rd), 32'h1);
      chk("raw_ready", 32'(in_ready), 32'h0);

      // RAW stall on R1, then writeback releases it.
      repeat (3) tick();
      chk("raw_stall3", 32'(stall_cnt), 32'd3);
      wb_we = 1'b1; wb_addr = 4'h1; wb_data = 16'hBEEF;
      #1;
      chk("wb_cycle_ready", 32'(in_ready), 32'(BYP));
      tick();
      wb_we = 1'b0;
      if (!BYP) begin
         #1;
         chk("post_wb_ready", 32'(in_ready), 32'h1);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("raw_valid", 32'(out_valid), 32'h1);
      chk("raw_a", 32'(out_a), 32'hBEEF);
      chk("raw_rd", 32'(out_rd), 32'h4);
      chk("raw_stall", 32'(stall_cnt), 32'(S_RAW));

      // Backpressure: slot full, not a hazard stall.
      in_valid = 1'b1; in_instr = 16'hC000;
      #1;
      chk("bp_ready", 32'(in_ready), 32'h0);
      tick(); tick();
      chk("bp_stall", 32'(stall_cnt), 32'(S_RAW));
      chk("bp_hold_a", 32'(out_a), 32'hBEEF);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      #1;
      chk("bp_release", 32'(in_ready), 32'h1);
      tick();

      // Immediate: rs2 field ignored even with R15 pending.
      in_instr = 16'h0F00;
      tick();
      in_instr = 16'h8A5F;
      #1;
      chk("imm_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("imm_b", 32'(out_b), 32'h000F);
      chk("imm_a", 32'(out_a), 32'h5555);
      chk("imm_rd", 32'(out_rd), 32'hA);

      // Flush a slot holding an R6 writer.
      in_valid = 1'b1; in_instr = 16'h0600;
      tick();
      out_ready = 1'b0; in_instr = 16'h0060;
      #1;
      chk("fl_hold_rd", 32'(out_rd), 32'h6);
      chk("fl_pre_ready", 32'(in_ready), 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("fl_valid", 32'(out_valid), 32'h0);
      chk("fl_r6_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("fl_r6_a", 32'(out_a), 32'h6666);

      // Async reset in the middle of a stall (R4 and R0 pending).
      in_valid = 1'b1; in_instr = 16'h0040;
      tick(); tick();
      chk("mid_stall_ready", 32'(in_ready), 32'h0);
      rst = 1'b1;
      #1;
      chk_zero_outputs("async_rst");
      chk("async_rst_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic.
      repeat (3000) begin
         tick();
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = 16'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         wb_we     = ($urandom_range(0, 9) < 3);
         wb_data   = 16'($urandom);
         q = {};
         for (int i = 0; i < 16; i++) if (m_pend[i]) q.push_back(i);
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            wb_addr = 4'(q[$urandom_range(0, q.size() - 1)]);
         else
            wb_addr = 4'($urandom_range(0, 15));
      end

      // Saturation of the stall counter on a long RAW stall.
      tick();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b1; in_instr = 16'h0100;
      tick();
      in_instr = 16'h0010;
      repeat (65540) tick();
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
      tick();
      chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the execute stage.
- Accepts 16-bit instructions over a valid/ready handshake and drives the register file read addresses combinationally.
- Registers the returned operands into one pipeline slot feeding execute.
- Keeps a 16-entry scoreboard of pending writes, snooped from the writeback port that also drives the register file's write side, and stalls on RAW/WAW hazards.

Parameters:
- DW, 16, data/operand width.
- AW, 4, register address width (2**AW registers).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
- in_instr  in  16  [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
- rf_r_addr1  out  AW  = in_instr[7:4], combinational.
- rf_r_addr2  out  AW  = in_instr[3:0], combinational.
- rf_r_data1  in  DW  register file read data 1 (combinational read).
- rf_r_data2  in  DW  register file read data 2.
- wb_we  in  1  writeback strobe (same signal as register file we).
- wb_addr  in  AW  writeback register.
- wb_data  in  DW  writeback data.
- flush  in  1  discard the slot content.
- out_valid  out  1  slot holds an instruction.
- out_ready  in  1  execute consumes when out_valid & out_ready.
- out_op  out  4  opcode.
- out_rd  out  AW  destination register.
- out_we  out  1  instruction writes rd.
- out_a  out  DW  operand A.
- out_b  out  DW  operand B.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async): out_valid=0, out_op/out_rd/out_we/out_a/out_b=0, scoreboard=0, stall_cnt=0.
- Instruction classes:
  - op 0x0-0x7: reg-reg, writes rd, reads rs1 and rs2.
  - op 0x8-0xB: immediate, writes rd, reads rs1; out_b = zero-extended imm4.
  - op 0xC-0xF: no write, reads rs1 and rs2; out_we=0.
- hazard = (sb[rs1]) | (reads_rs2 & sb[rs2]) | (writes_rd & sb[rd]).
- slot_free = ~out_valid | out_ready.
- in_ready = slot_free & ~hazard & ~flush. It is combinational and never depends on in_valid.
- Accept: on the next edge the slot loads op, rd, we, out_a=rf_r_data1 and out_b, with out_valid=1. Latency: 1 cycle from accept to out_valid.
- On accept, sb[rd] is set if writes_rd.
- out_valid drops to 0 on consume without a simultaneous accept. Slot contents hold while out_valid & ~out_ready.
- Scoreboard clear: sb[wb_addr] is cleared when wb_we.
- Same register set and cleared in one cycle: set wins. This is unreachable given the WAW stall, but it is defined anyway.
- flush:
  - out_valid is cleared next edge.
  - The flushed slot's sb[out_rd] is cleared if out_we and out_valid.
  - No accept occurs in a flush cycle.
  - flush with empty slot: no effect.
- stall_cnt increments when in_valid & slot_free & hazard & ~flush. It saturates at all-ones.
- Write-before-read: a writeback in the same cycle is not visible on rf_r_data (register file updates on the edge), so its sb bit still blocks that cycle.

Optional Feature:
- OPERAND_FETCH_WB_BYPASS_EN defined:
  - A hazard bit is ignored when wb_we & wb_addr matches that register in the same cycle.
  - The matching source operand takes wb_data instead of rf_r_data.
  - For a rd/WAW match, the instruction is accepted and its sb[rd] is set; set wins over the clear.
  - Saves one stall cycle per RAW.
- Undefined: the stall persists one extra cycle until sb clears; no wb_data path exists.

Decomposition:
- Shared package (cpu_pkg): DW, AW, opcode field positions, and class ranges/localparams (OP_IMM_BASE=4'h8, OP_NOWR_BASE=4'hC).
- Sub-module scoreboard: 2**AW bits, set port (en, addr), clear port ×2 (writeback, flush), two read-address hazard lookups plus rd lookup.

Test Plan:
- Reset with in_valid=1, instr 0x0123 → in_ready=1; next cycle out_valid=1, out_a=R2, out_b=R3, sb[1]=1.
- RAW: 0x0123 then 0x1415, no writeback → second instr in_ready=0, stall_cnt counts up. wb_we=1, wb_addr=1 for one cycle → accepted one cycle later, or same cycle with out_a=wb_data when WB_BYPASS_EN.
- Backpressure: out_ready=0 with slot full → in_ready=0, outputs stable, stall_cnt unchanged (not a hazard stall).
- Immediate 0x8A5F → out_b=16'h000F; rs2 field ignored for hazard even when sb[15]=1.
- Flush with slot holding rd=6 writer → out_valid=0 next cycle, sb[6]=0; a following instr reading R6 is accepted immediately.
- Async reset asserted mid-stall with sb nonzero → all outputs and sb are 0 before the next clock edge; stall_cnt saturation forced by preload 16'hFFFF stays at 16'hFFFF.
